// File: rtl/regfile_mp.sv
// Multi-port register file with per-register scoreboard for the CPU32 pipeline.
// Reads are registered (latency 1); optional write-to-read bypass and hardwired zero register.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NREGS    = 32,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NR-1:0]     rd_en,
  input  logic [NR*AW-1:0]  ra,
  output logic [NR*DW-1:0]  rd,
  output logic [NR-1:0]     rd_valid,
  output logic [NR-1:0]     rd_busy,
  input  logic [NW-1:0]     we,
  input  logic [NW*AW-1:0]  wa,
  input  logic [NW*DW-1:0]  wd,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_a,
  output logic [NREGS-1:0]  busy
);

  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  // An address is usable when it maps to an implemented, writable register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
    return a[IW-1:0];
  endfunction

  logic [DW-1:0]    mem_q [NREGS];
  logic [DW-1:0]    mem_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic [AW-1:0]    wa_a [NW];
  logic [DW-1:0]    wd_a [NW];
  logic [NW-1:0]    wr_ok;
  logic             rsv_ok;

  genvar gi;

  generate
    for (gi = 0; gi < NW; gi++) begin : g_wport
      assign wa_a[gi]  = wa[gi*AW +: AW];
      assign wd_a[gi]  = wd[gi*DW +: DW];
      assign wr_ok[gi] = we[gi] && addr_ok(wa_a[gi]);
    end
  endgenerate

  assign rsv_ok = rsv_en && addr_ok(rsv_a);

  // Ascending port order lets the highest-index writer win a collision;
  // the reservation is applied last so a new producer overrides a retiring one.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int j = 0; j < NW; j++) begin
      if (wr_ok[j]) begin
        mem_d[idx(wa_a[j])]  = wd_a[j];
        busy_d[idx(wa_a[j])] = 1'b0;
      end
    end
    if (rsv_ok) begin
      busy_d[idx(rsv_a)] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  generate
    for (gi = 0; gi < NR; gi++) begin : g_rport
      logic [AW-1:0] a;
      logic          hit;
      logic [DW-1:0] fwd;
      logic [DW-1:0] data_q;
      logic [DW-1:0] data_d;
      logic          bsy_q;
      logic          bsy_d;
      logic          vld_q;
      logic          vld_d;

      assign a = ra[gi*AW +: AW];

      always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int j = 0; j < NW; j++) begin
          if ((BYPASS != 0) && wr_ok[j] && (wa_a[j] == a)) begin
            hit = 1'b1;
            fwd = wd_a[j];
          end
        end
        data_d = data_q;
        bsy_d  = bsy_q;
        vld_d  = rd_en[gi];
        if (rd_en[gi]) begin
          if (!addr_ok(a)) begin
            data_d = '0;
            bsy_d  = 1'b0;
          end else if (hit) begin
            // Forwarded data is the producer's result, so it is no longer pending.
            data_d = fwd;
            bsy_d  = 1'b0;
          end else begin
            data_d = mem_q[idx(a)];
            bsy_d  = busy_q[idx(a)];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= '0;
          bsy_q  <= 1'b0;
          vld_q  <= 1'b0;
        end else begin
          data_q <= data_d;
          bsy_q  <= bsy_d;
          vld_q  <= vld_d;
        end
      end

      assign rd[gi*DW +: DW] = data_q;
      assign rd_valid[gi]    = vld_q;
      assign rd_busy[gi]     = bsy_q;
    end
  endgenerate

endmodule
